// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter
// Shares the single L2 line-fill port between the L1 D-cache (dc), the L1
// I-cache (ic) and the prefetcher (pf). One fill is in flight at a time.
// Demand requesters alternate round-robin. The prefetcher is served when
// demand is idle, or when it has lost STARVE_LIMIT arbitrations in a row.
// The fill line is broadcast on fill_data. Only the owner sees its done pulse.

module l2_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_BITS    = 256,
  parameter int OFFSET_BITS  = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  dc_req,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  output logic                  dc_done,

  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_done,

  input  logic                  pf_req,
  input  logic [ADDR_WIDTH-1:0] pf_addr,
  output logic                  pf_done,

  output logic [LINE_BITS-1:0]  fill_data,
  output logic [2:0]            grant,

  output logic [ADDR_WIDTH-1:0] l2_addr,
  output logic                  l2_request,
  input  logic [LINE_BITS-1:0]  l2_data,
  input  logic                  l2_done
);

  // The starvation counter is 4 bits wide, so the limit is truncated to that width.
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // One-hot grant encodings. Bit 0 is dc, bit 1 is ic and bit 2 is pf.
  localparam logic [2:0] GRANT_NONE = 3'b000;
  localparam logic [2:0] GRANT_DC   = 3'b001;
  localparam logic [2:0] GRANT_IC   = 3'b010;
  localparam logic [2:0] GRANT_PF   = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                  state;

  // rr_last names the demand requester served most recently: 0 is dc, 1 is ic.
  logic                    rr_last;
  logic [3:0]              starve_cnt;

  logic                    any_req;
  logic                    pf_starved;
  logic [2:0]              next_grant;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [ADDR_WIDTH-1:0]   aligned_addr;
  logic                    busy;

  assign any_req    = dc_req | ic_req | pf_req;
  assign pf_starved = pf_req && (starve_cnt == STARVE_MAX);
  assign busy       = (state == BUSY);

  // Choose the next owner. A starved prefetch wins first. A dc/ic tie goes
  // to the side that was not served last. Otherwise the single demand
  // requester wins, and the prefetcher gets the port when demand is idle.
  always_comb begin
    next_grant = GRANT_NONE;
    if (pf_starved) begin
      next_grant = GRANT_PF;
    end else if (dc_req && ic_req) begin
      next_grant = rr_last ? GRANT_DC : GRANT_IC;
    end else if (dc_req) begin
      next_grant = GRANT_DC;
    end else if (ic_req) begin
      next_grant = GRANT_IC;
    end else if (pf_req) begin
      next_grant = GRANT_PF;
    end
  end

  // Route the winner's address and clear the line offset before it goes to L2.
  always_comb begin
    sel_addr = '0;
    unique case (next_grant)
      GRANT_DC: sel_addr = dc_addr;
      GRANT_IC: sel_addr = ic_addr;
      GRANT_PF: sel_addr = pf_addr;
      default:  sel_addr = '0;
    endcase
    aligned_addr = {sel_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  end

  // Arbitration FSM. It holds the registered grant, L2 request and address,
  // plus the round-robin pointer and the prefetch starvation counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= GRANT_NONE;
      l2_request <= 1'b0;
      l2_addr    <= '0;
      rr_last    <= 1'b1;
      starve_cnt <= 4'd0;
    end else begin
      if (!pf_req) begin
        starve_cnt <= 4'd0;
      end else if (state == IDLE) begin
        if (next_grant == GRANT_PF) begin
          starve_cnt <= 4'd0;
        end else if (starve_cnt != STARVE_MAX) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end

      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= next_grant;
            l2_addr    <= aligned_addr;
            l2_request <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (l2_done) begin
            if (grant == GRANT_DC) begin
              rr_last <= 1'b0;
            end else if (grant == GRANT_IC) begin
              rr_last <= 1'b1;
            end
            grant      <= GRANT_NONE;
            l2_request <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Pass L2 completion straight through to the current owner only.
  // Gating with BUSY drops a stray l2_done in IDLE, and reset clears it
  // at once because state is reset asynchronously.
  always_comb begin
    dc_done = busy && grant[0] && l2_done;
    ic_done = busy && grant[1] && l2_done;
    pf_done = busy && grant[2] && l2_done;
  end

  assign fill_data = l2_data;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter
// Directed bench for l2_port_arbiter. A vector table drives a single-requester
// session. Hand-written sequences then cover round-robin, prefetch
// starvation and reset during a fill.

module tb_l2_port_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk;
  logic          reset;
  logic          dc_req, ic_req, pf_req;
  logic [AW-1:0] dc_addr, ic_addr, pf_addr;
  logic          dc_done, ic_done, pf_done;
  logic [LW-1:0] fill_data;
  logic [2:0]    grant;
  logic [AW-1:0] l2_addr;
  logic          l2_request;
  logic [LW-1:0] l2_data;
  logic          l2_done;

  int checks = 0;
  int errors = 0;

  l2_port_arbiter #(
    .ADDR_WIDTH  (AW),
    .LINE_BITS   (LW),
    .OFFSET_BITS (5),
    .STARVE_LIMIT(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dc_req    (dc_req),
    .dc_addr   (dc_addr),
    .dc_done   (dc_done),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_done   (ic_done),
    .pf_req    (pf_req),
    .pf_addr   (pf_addr),
    .pf_done   (pf_done),
    .fill_data (fill_data),
    .grant     (grant),
    .l2_addr   (l2_addr),
    .l2_request(l2_request),
    .l2_data   (l2_data),
    .l2_done   (l2_done)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic          dc_req;
    logic          ic_req;
    logic          pf_req;
    logic          l2_done;
    logic [AW-1:0] dc_addr;
    logic [AW-1:0] ic_addr;
    logic [AW-1:0] pf_addr;
    logic [2:0]    exp_grant;
    logic          exp_req;
    logic [2:0]    exp_done;
    logic [AW-1:0] exp_addr;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs[NVEC];

  logic [LW-1:0] line_a5;
  logic [2:0]    rr_exp[6];
  logic [2:0]    st_exp[10];

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic d, input logic i, input logic p,
                               input logic done);
    dc_req  = d;
    ic_req  = i;
    pf_req  = p;
    l2_done = done;
  endtask

  task automatic checkOutput(input string name, input logic [LW-1:0] actual,
                             input logic [LW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [AW-1:0] addrOf(input logic [2:0] g);
    case (g)
      3'b001:  return 32'h0000_0100;
      3'b010:  return 32'h0000_0200;
      3'b100:  return 32'h0000_8040;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    line_a5 = {32{8'hA5}};
    l2_data = line_a5;
    reset   = 1'b1;
    dc_addr = 32'h0;
    ic_addr = 32'h0;
    pf_addr = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Single ic fill, a stray l2_done in IDLE, then a prefetch-only fill.
    //            dc    ic    pf    done  dc_addr       ic_addr       pf_addr       grant   req   done    l2_addr
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_1234, 32'h0,        3'b000, 1'b0, 3'b000, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_1234, 32'h0,        3'b010, 1'b1, 3'b000, 32'h0000_1220};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_1234, 32'h0,        3'b010, 1'b1, 3'b000, 32'h0000_1220};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_1234, 32'h0,        3'b010, 1'b1, 3'b000, 32'h0000_1220};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h0000_1234, 32'h0,        3'b010, 1'b1, 3'b010, 32'h0000_1220};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_1234, 32'h0,        3'b000, 1'b0, 3'b000, 32'h0000_1220};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,         32'h0,        3'b000, 1'b0, 3'b000, 32'h0000_1220};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         32'h0,        3'b000, 1'b0, 3'b000, 32'h0000_1220};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,         32'h0000_8044, 3'b000, 1'b0, 3'b000, 32'h0000_1220};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h5555_5555, 32'h0000_8044, 3'b100, 1'b1, 3'b000, 32'h0000_8040};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0,         32'h0000_8044, 3'b100, 1'b1, 3'b100, 32'h0000_8040};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         32'h0,        3'b000, 1'b0, 3'b000, 32'h0000_8040};

    // The last demand owner was ic, so the tie goes to dc first.
    rr_exp = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
    // pf wins after 4 losses, its counter clears, then it wins again after 4 more.
    st_exp = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b100,
               3'b001, 3'b010, 3'b001, 3'b010, 3'b100};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset l2_request", l2_request, 1'b0);
    checkOutput("reset grant", grant, 3'b000);
    checkOutput("reset l2_addr", l2_addr, 32'h0);
    checkOutput("reset dones", {pf_done, ic_done, dc_done}, 3'b000);
    reset = 1'b0;

    // Table-driven single-requester session.
    for (int v = 0; v < NVEC; v++) begin
      nextCycle();
      dc_addr = vecs[v].dc_addr;
      ic_addr = vecs[v].ic_addr;
      pf_addr = vecs[v].pf_addr;
      applyStimulus(vecs[v].dc_req, vecs[v].ic_req, vecs[v].pf_req, vecs[v].l2_done);
      #2;
      checkOutput($sformatf("vec%0d grant", v), grant, vecs[v].exp_grant);
      checkOutput($sformatf("vec%0d l2_request", v), l2_request, vecs[v].exp_req);
      checkOutput($sformatf("vec%0d dones", v), {pf_done, ic_done, dc_done}, vecs[v].exp_done);
      checkOutput($sformatf("vec%0d l2_addr", v), l2_addr, vecs[v].exp_addr);
      if (vecs[v].l2_done) begin
        checkOutput($sformatf("vec%0d fill_data", v), fill_data, line_a5);
      end
    end

    // Round-robin between dc and ic, both held, with a one-cycle L2 answer.
    dc_addr = 32'h0000_0100;
    ic_addr = 32'h0000_0200;
    pf_addr = 32'h0000_8040;
    for (int t = 0; t < 6; t++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      #2;
      checkOutput($sformatf("rr%0d idle l2_request", t), l2_request, 1'b0);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      #2;
      checkOutput($sformatf("rr%0d grant", t), grant, rr_exp[t]);
      checkOutput($sformatf("rr%0d l2_addr", t), l2_addr, addrOf(rr_exp[t]));
      checkOutput($sformatf("rr%0d dones", t), {pf_done, ic_done, dc_done}, rr_exp[t]);
    end

    // Prefetch starvation with continuous demand.
    for (int t = 0; t < 10; t++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      #2;
      checkOutput($sformatf("st%0d idle l2_request", t), l2_request, 1'b0);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      #2;
      checkOutput($sformatf("st%0d grant", t), grant, st_exp[t]);
      checkOutput($sformatf("st%0d l2_addr", t), l2_addr, addrOf(st_exp[t]));
      checkOutput($sformatf("st%0d dones", t), {pf_done, ic_done, dc_done}, st_exp[t]);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("post-starve grant", grant, 3'b000);

    // Asynchronous reset while dc owns the port.
    nextCycle();
    dc_addr = 32'h0000_013F;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("rst busy grant", grant, 3'b001);
    checkOutput("rst busy l2_addr", l2_addr, 32'h0000_0120);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("rst pre dc_done", dc_done, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("rst async l2_request", l2_request, 1'b0);
    checkOutput("rst async grant", grant, 3'b000);
    checkOutput("rst async dc_done", dc_done, 1'b0);
    checkOutput("rst async l2_addr", l2_addr, 32'h0);
    nextCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    checkOutput("post-rst dones", {pf_done, ic_done, dc_done}, 3'b000);
    checkOutput("post-rst l2_request", l2_request, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("post-rst idle l2_request", l2_request, 1'b0);
    checkOutput("post-rst idle grant", grant, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
